// File: rtl/axi_lite_dmem_if.sv
// AXI4-lite bus bundle between the execute-stage master and the data memory slave.
// Signals: AW (awvalid/awready/awaddr/awprot), W (wvalid/wready/wdata/wstrb),
// B (bvalid/bready/bresp), AR (arvalid/arready/araddr/arprot), R (rvalid/rready/rdata/rresp).
// Modports: master drives valids/payloads and B/R readies; slave drives the rest.
interface axi_lite_dmem_if;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awprot,
        output axi_wvalid, axi_wdata, axi_wstrb,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arprot,
        output axi_rready,
        input  axi_awready, axi_wready,
        input  axi_bvalid, axi_bresp,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awprot,
        input  axi_wvalid, axi_wdata, axi_wstrb,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arprot,
        input  axi_rready,
        output axi_awready, axi_wready,
        output axi_bvalid, axi_bresp,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp
    );
endinterface

// File: rtl/axi_lite_dmem_slave.sv
// AXI4-lite data memory responder: word-addressed array with byte-strobe writes.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset (memory contents are not reset)
//   bus - AXI4-lite slave modport; independent read and write channels, one
//         outstanding transaction each; out-of-range accesses answer SLVERR.
module axi_lite_dmem_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_dmem_if.slave  bus
);

    localparam int unsigned IdxW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SpanBytes = 33'(MEM_WORDS) << 2;
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    function automatic logic in_range(input logic [31:0] a);
        // 33-bit compare so the top of a window ending at 4 GiB still decodes
        return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SpanBytes);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] a);
        return IdxW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_q [MEM_WORDS];

    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        arready_q, arready_d;
    logic        aw_full_q, aw_full_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic        w_full_q, w_full_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic            commit, wr_ok, rd_ok;
    logic [31:0]     wr_addr, wr_data;
    logic [3:0]      wr_strb;
    logic [IdxW-1:0] wr_idx, rd_idx;

    always_comb begin
        aw_hs = bus.axi_awvalid & awready_q;
        w_hs  = bus.axi_wvalid & wready_q;
        ar_hs = bus.axi_arvalid & arready_q;
        b_hs  = bvalid_q & bus.axi_bready;
        r_hs  = rvalid_q & bus.axi_rready;

        // Prefer the buffered beat; otherwise use the one handshaking this edge
        wr_addr = aw_full_q ? aw_addr_q : bus.axi_awaddr;
        wr_data = w_full_q ? w_data_q : bus.axi_wdata;
        wr_strb = w_full_q ? w_strb_q : bus.axi_wstrb;
        commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
        wr_ok   = in_range(wr_addr);
        wr_idx  = word_idx(wr_addr);
        rd_ok   = in_range(bus.axi_araddr);
        rd_idx  = word_idx(bus.axi_araddr);

        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = bus.axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.axi_wdata;
            w_strb_d = bus.axi_wstrb;
        end
        if (b_hs) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RespOkay : RespSlvErr;
        end
        // Each address/data channel reopens only once its buffer is empty and no B is pending
        awready_d = ~aw_full_d & ~bvalid_d;
        wready_d  = ~w_full_d & ~bvalid_d;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_ok ? mem_q[rd_idx] : 32'h0;
            rresp_d  = rd_ok ? RespOkay : RespSlvErr;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= 32'h0;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RespOkay;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Array has no reset; same-edge reads see the old word (read-before-write)
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.axi_awready = awready_q;
    assign bus.axi_wready  = wready_q;
    assign bus.axi_arready = arready_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.axi_rvalid  = rvalid_q;
    assign bus.axi_rdata   = rdata_q;
    assign bus.axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// Self-checking bench for axi_lite_dmem_slave: directed scenarios plus randomized
// traffic, checked against an array-based reference of the memory map.
module tb_axi_lite_dmem_slave;

    localparam int unsigned WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [31:0] ref_mem [WORDS];

    axi_lite_dmem_if bus ();

    axi_lite_dmem_slave #(
        .MEM_WORDS (WORDS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_ok(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_ok(a) ? ref_mem[m_idx(a)] : 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_ok(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
        int cyc;
        bit aw_done, w_done, aw_now, w_now;
        logic [1:0] exp_resp;
        cyc = 0;
        aw_done = 0;
        w_done = 0;
        exp_resp = m_ok(addr) ? 2'b00 : 2'b10;
        while (!(aw_done && w_done)) begin
            bus.axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.axi_awaddr  = addr;
            bus.axi_wvalid  = !w_done && (cyc >= w_dly);
            bus.axi_wdata   = data;
            bus.axi_wstrb   = strb;
            if (aw_done) check("wr_awready_held_low", 32'(bus.axi_awready), 32'h0);
            if (w_done)  check("wr_wready_held_low", 32'(bus.axi_wready), 32'h0);
            aw_now = bus.axi_awvalid && bus.axi_awready;
            w_now  = bus.axi_wvalid && bus.axi_wready;
            tick();
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
            if (!(aw_done && w_done)) check("wr_bvalid_early", 32'(bus.axi_bvalid), 32'h0);
            if (cyc > 40) begin
                check("wr_handshake_timeout", 32'h0, 32'h1);
                break;
            end
        end
        bus.axi_awvalid = 1'b0;
        bus.axi_wvalid  = 1'b0;
        m_write(addr, data, strb);
        check("wr_bvalid", 32'(bus.axi_bvalid), 32'h1);
        check("wr_bresp", 32'(bus.axi_bresp), 32'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("wr_bp_bvalid", 32'(bus.axi_bvalid), 32'h1);
            check("wr_bp_bresp", 32'(bus.axi_bresp), 32'(exp_resp));
            check("wr_bp_awready", 32'(bus.axi_awready), 32'h0);
            check("wr_bp_wready", 32'(bus.axi_wready), 32'h0);
        end
        bus.axi_bready = 1'b1;
        tick();
        bus.axi_bready = 1'b0;
        check("wr_b_done_bvalid", 32'(bus.axi_bvalid), 32'h0);
        check("wr_b_done_awready", 32'(bus.axi_awready), 32'h1);
        check("wr_b_done_wready", 32'(bus.axi_wready), 32'h1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = m_read(addr);
        exp_resp = m_ok(addr) ? 2'b00 : 2'b10;
        bus.axi_arvalid = 1'b1;
        bus.axi_araddr  = addr;
        check("rd_arready", 32'(bus.axi_arready), 32'h1);
        tick();
        bus.axi_arvalid = 1'b0;
        check("rd_rvalid", 32'(bus.axi_rvalid), 32'h1);
        check("rd_rdata", bus.axi_rdata, exp_data);
        check("rd_rresp", 32'(bus.axi_rresp), 32'(exp_resp));
        check("rd_arready_low", 32'(bus.axi_arready), 32'h0);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("rd_bp_rvalid", 32'(bus.axi_rvalid), 32'h1);
            check("rd_bp_rdata", bus.axi_rdata, exp_data);
            check("rd_bp_rresp", 32'(bus.axi_rresp), 32'(exp_resp));
            check("rd_bp_arready", 32'(bus.axi_arready), 32'h0);
        end
        bus.axi_rready = 1'b1;
        tick();
        bus.axi_rready = 1'b0;
        check("rd_done_rvalid", 32'(bus.axi_rvalid), 32'h0);
        check("rd_done_arready", 32'(bus.axi_arready), 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 15)) * 4;
        else a = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 63)) * 4;
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 32'h0;
        bus.axi_awvalid = 1'b0;
        bus.axi_awaddr  = 32'h0;
        bus.axi_awprot  = 3'h0;
        bus.axi_wvalid  = 1'b0;
        bus.axi_wdata   = 32'h0;
        bus.axi_wstrb   = 4'h0;
        bus.axi_bready  = 1'b0;
        bus.axi_arvalid = 1'b0;
        bus.axi_araddr  = 32'h0;
        bus.axi_arprot  = 3'h0;
        bus.axi_rready  = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_awready", 32'(bus.axi_awready), 32'h0);
        check("rst_wready", 32'(bus.axi_wready), 32'h0);
        check("rst_arready", 32'(bus.axi_arready), 32'h0);
        check("rst_bvalid", 32'(bus.axi_bvalid), 32'h0);
        check("rst_rvalid", 32'(bus.axi_rvalid), 32'h0);
        check("rst_bresp", 32'(bus.axi_bresp), 32'h0);
        check("rst_rresp", 32'(bus.axi_rresp), 32'h0);
        check("rst_rdata", bus.axi_rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_awready", 32'(bus.axi_awready), 32'h1);
        check("post_rst_wready", 32'(bus.axi_wready), 32'h1);
        check("post_rst_arready", 32'(bus.axi_arready), 32'h1);

        // Known contents for the randomized window (words 0..15)
        for (int i = 0; i < 16; i++) do_write(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, 0);

        // Aligned word write then read
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h10, 0);
        check("word_write_value", m_read(32'h10), 32'hDEADBEEF);

        // Byte and halfword strobes
        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(32'h20, 32'h000000AA, 4'b0001, 0, 0, 0);
        do_read(32'h20, 0);
        check("byte_strobe_model", m_read(32'h20), 32'h112233AA);
        do_write(32'h20, 32'h0000BBCC, 4'b0011, 1, 0, 0);
        do_read(32'h20, 0);
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
        do_read(32'h20, 0);

        // Decoupled ordering, then backpressure on B and R
        do_write(32'h24, 32'hCAFEF00D, 4'hF, 3, 0, 0);
        do_read(32'h24, 0);
        do_write(32'h28, 32'h0BADC0DE, 4'hF, 0, 3, 0);
        do_read(32'h28, 0);
        do_write(32'h2C, 32'h12345678, 4'hF, 0, 0, 5);
        do_read(32'h2C, 5);

        // Out of range and ignored low address bits
        do_write(32'h1000, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        do_read(32'h0, 0);
        do_read(32'h1000, 0);
        do_read(32'h13, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(rand_addr(), $urandom_range(0, 2));
        end

        // Commit and AR to the same word on the same edge
        do_write(32'h40, 32'h0, 4'hF, 0, 0, 0);
        bus.axi_awvalid = 1'b1;
        bus.axi_awaddr  = 32'h40;
        bus.axi_wvalid  = 1'b1;
        bus.axi_wdata   = 32'h55555555;
        bus.axi_wstrb   = 4'hF;
        bus.axi_arvalid = 1'b1;
        bus.axi_araddr  = 32'h40;
        tick();
        bus.axi_awvalid = 1'b0;
        bus.axi_wvalid  = 1'b0;
        bus.axi_arvalid = 1'b0;
        check("coll_bvalid", 32'(bus.axi_bvalid), 32'h1);
        check("coll_rvalid", 32'(bus.axi_rvalid), 32'h1);
        check("coll_rdata_old", bus.axi_rdata, m_read(32'h40));
        m_write(32'h40, 32'h55555555, 4'hF);
        bus.axi_bready = 1'b1;
        bus.axi_rready = 1'b1;
        tick();
        bus.axi_bready = 1'b0;
        bus.axi_rready = 1'b0;
        do_read(32'h40, 0);

        // Reset while a write response is pending
        bus.axi_awvalid = 1'b1;
        bus.axi_awaddr  = 32'h44;
        bus.axi_wvalid  = 1'b1;
        bus.axi_wdata   = 32'h77778888;
        bus.axi_wstrb   = 4'hF;
        tick();
        bus.axi_awvalid = 1'b0;
        bus.axi_wvalid  = 1'b0;
        m_write(32'h44, 32'h77778888, 4'hF);
        check("rstmid_bvalid_before", 32'(bus.axi_bvalid), 32'h1);
        rst = 1'b1;
        tick();
        check("rstmid_bvalid", 32'(bus.axi_bvalid), 32'h0);
        check("rstmid_awready", 32'(bus.axi_awready), 32'h0);
        rst = 1'b0;
        tick();
        check("rstmid_awready_rel", 32'(bus.axi_awready), 32'h1);
        check("rstmid_wready_rel", 32'(bus.axi_wready), 32'h1);
        check("rstmid_arready_rel", 32'(bus.axi_arready), 32'h1);
        do_read(32'h44, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so a stuck handshake cannot hang the run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_dmem_slave.md
Name: axi_lite_dmem_slave

Overview:
AXI4-lite responder holding the core's data memory as an internal word-addressed array with byte-strobe writes. It is the other end of the execute stage's AXI4-lite master port, serving store transactions (AW/W/B) and load transactions (AR/R). The read and write channels are independent, with one outstanding transaction per channel. Out-of-range accesses complete with SLVERR.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the array; must be a power of 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_awaddr  in  32  write byte address
axi_awprot  in  3  ignored
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_wdata  in  32  write data, lane-aligned per AXI
axi_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i]
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_araddr  in  32  read byte address
axi_arprot  in  3  ignored
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_rdata  out  32  read data
axi_rresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Clocking: single clock domain; all outputs registered; reset is synchronous and active-high.
- Reset values: awready, wready, arready, bvalid and rvalid are 0; bresp and rresp are 00; rdata is 0; AW/W holding buffers are cleared.
- Cycle after reset release: awready, wready and arready go to 1. Memory contents are not reset.
- Decode:
  - in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored
  - no lane shifting is applied to data
- Write channel:
  - An AW handshake (valid & ready at an edge) latches awaddr into the AW buffer and drops awready.
  - A W handshake likewise latches wdata/wstrb into the W buffer and drops wready.
  - The channels may handshake in either order or on the same edge.
  - Commit edge: the edge at which both AW and W are available (buffered or handshaking now). At that edge:
    - if in range, update the lanes selected by wstrb; other lanes are unchanged; wstrb=0000 writes nothing but still responds OKAY
    - if out of range, write nothing
    - set bvalid=1 and bresp=00 (in range) or 10 (out of range)
    - clear both buffers; hold awready=wready=0
  - The bvalid/bresp pair is held stable until bready. On the B handshake edge, bvalid goes to 0; awready and wready go to 1 on the same edge.
  - Latency: bvalid is asserted the cycle after the later of the AW/W handshakes.
- Read channel:
  - On the AR handshake edge: rdata = mem[index] (0 if out of range), rresp = 00/10, rvalid=1, arready=0.
  - Latency: 1 cycle.
  - rdata/rresp are held stable while rvalid & ~rready.
  - On the R handshake edge: rvalid=0, arready=1.
- Simultaneous commit and AR on the same word at the same edge: the read returns the pre-write data (read-before-write).
- Channels never stall each other. A pending B does not block AR, and a pending R does not block AW/W.
- Reset mid-transaction: pending bvalid/rvalid drop at the next edge. Half-received AW or W is discarded. Memory is unchanged except by writes already committed.
- awprot/arprot are ignored.

Test Plan:
- Aligned word write then read: AW 0x10 with W 0xDEADBEEF, wstrb 1111 (same cycle); bready=1 -> bvalid the next cycle with bresp 00. Then AR 0x10 -> rvalid 1 cycle later with rdata 0xDEADBEEF, rresp 00.
- Byte/half strobes: word 0x20 preset to 0x11223344. Write wdata 0x000000AA, wstrb 0001 -> read gives 0x112233AA. Then write wdata 0x0000BBCC, wstrb 0011 -> read gives 0x1122BBCC.
- Decoupled AW/W ordering: W first, AW 3 cycles later -> wready stays 0 in between; bvalid the cycle after the AW handshake; memory updated. Repeat with AW first and W late.
- Backpressure: hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0. Hold rready=0 -> rdata stable, arready=0. Release each -> ready returns to 1 on the same edge as the handshake.
- Out of range (MEM_WORDS=1024): write to 0x1000 -> bresp 10 and memory unchanged. Read from 0x1000 -> rresp 10, rdata 0. Read of 0x13 -> returns word 0x10.
- Collision and reset: commit of 0x55555555 to 0x40 on the same edge as AR 0x40 (old value 0x0) -> rdata 0x0, and a later read returns 0x55555555. Assert rst while bvalid=1 -> bvalid=0 the next cycle and all readies=1 the cycle after release.
